// File: rtl/bus_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// bus_burst_mem_slave
//
// Burst-capable memory slave for the shared system bus. It decodes an address
// window of 2^ADDR_WORDS_LOG2 32-bit words starting at BASE_ADDRESS. Read
// bursts stream one word per cycle after READ_LATENCY idle cycles and close
// with a one-cycle end_transaction_out. Write bursts are absorbed lane-wise
// under the byte enables latched at begin, with WAIT_STATES busy cycles after
// every accepted word. Misaligned hits answer with a one-cycle error.
//
// Ports:
//   clock                 sole clock, rising edge
//   reset                 asynchronous, active-low
//   begin_transaction_in  transaction start (address/control valid)
//   end_transaction_in    master ends or aborts the transaction
//   read_n_write_in       1 = read, 0 = write (sampled with begin)
//   byte_enables_in[3:0]  write lane enables (sampled with begin)
//   burst_size_in[7:0]    words minus one (sampled with begin)
//   address_data_in[31:0] byte address at begin, write data afterwards
//   data_valid_in         write data valid
//   busy_out              write back-pressure
//   data_valid_out        read data valid
//   end_transaction_out   slave-terminated transaction (read done or error)
//   error_out             transaction error
//   address_data_out      read data, 0 while data_valid_out is low
// ---------------------------------------------------------------------------
module bus_burst_mem_slave #(
    parameter logic [31:0] BASE_ADDRESS    = 32'h0000_0000,
    parameter int          ADDR_WORDS_LOG2 = 10,
    parameter int          READ_LATENCY    = 1,
    parameter int          WAIT_STATES     = 0
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        begin_transaction_in,
    input  logic        end_transaction_in,
    input  logic        read_n_write_in,
    input  logic [3:0]  byte_enables_in,
    input  logic [7:0]  burst_size_in,
    input  logic [31:0] address_data_in,
    input  logic        data_valid_in,
    output logic        busy_out,
    output logic        data_valid_out,
    output logic        end_transaction_out,
    output logic        error_out,
    output logic [31:0] address_data_out
);

    localparam int N     = ADDR_WORDS_LOG2;
    localparam int DEPTH = 1 << N;

    localparam logic [N-1:0] PTR_ONE   = 1;
    localparam logic [3:0]   LAT_INIT  = (READ_LATENCY > 0) ? 4'(READ_LATENCY - 1) : 4'd0;
    localparam logic [3:0]   WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    typedef enum logic [2:0] {
        IDLE,
        RD_LAT,
        RD_DATA,
        RD_END,
        WR_DATA,
        ERR
    } state_t;

    state_t       state_reg, state_next;
    logic [N-1:0] ptr_reg, ptr_next;
    // Reads: words still to fetch after the one on the bus.
    // Writes: words still to store (burst_size_in + 1 at begin).
    logic [8:0]   count_reg, count_next;
    logic [3:0]   lat_reg, lat_next;
    logic [3:0]   wait_reg, wait_next;
    logic [3:0]   be_reg, be_next;
    logic         busy_reg, busy_next;
    logic         valid_reg, valid_next;
    logic         end_reg, end_next;
    logic         err_reg, err_next;

    logic         hit;
    logic         aligned;
    logic         accept;
    logic         issue;      // fetch one read word at this edge
    logic         mem_we;     // store the current write word at this edge
    logic [N-1:0] mem_addr;
    logic [7:0]   rd_lanes [4];

    assign hit     = (address_data_in[31:N+2] == BASE_ADDRESS[31:N+2]);
    assign aligned = (address_data_in[1:0] == 2'b00);
    assign accept  = data_valid_in && !busy_reg;

    // The first read word is fetched straight from the begin address when
    // there is no latency, so the memory is addressed from the bus in IDLE and
    // from the running pointer everywhere else.
    assign mem_addr = (state_reg == IDLE) ? address_data_in[N+1:2] : ptr_reg;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        count_next = count_reg;
        lat_next   = lat_reg;
        wait_next  = wait_reg;
        be_next    = be_reg;
        busy_next  = 1'b0;
        valid_next = 1'b0;
        end_next   = 1'b0;
        err_next   = 1'b0;
        issue      = 1'b0;
        mem_we     = 1'b0;

        case (state_reg)
            IDLE: begin
                if (begin_transaction_in && hit) begin
                    if (!aligned) begin
                        state_next = ERR;
                        err_next   = 1'b1;
                        end_next   = 1'b1;
                    end else begin
                        ptr_next = address_data_in[N+1:2];
                        be_next  = byte_enables_in;
                        if (read_n_write_in) begin
                            count_next = {1'b0, burst_size_in};
                            if (READ_LATENCY == 0) begin
                                issue      = 1'b1;
                                valid_next = 1'b1;
                                ptr_next   = address_data_in[N+1:2] + PTR_ONE;
                                state_next = RD_DATA;
                            end else begin
                                lat_next   = LAT_INIT;
                                state_next = RD_LAT;
                            end
                        end else begin
                            count_next = {1'b0, burst_size_in} + 9'd1;
                            state_next = WR_DATA;
                        end
                    end
                end
            end

            RD_LAT: begin
                if (end_transaction_in) begin
                    state_next = IDLE;
                end else if (lat_reg == 4'd0) begin
                    issue      = 1'b1;
                    valid_next = 1'b1;
                    ptr_next   = ptr_reg + PTR_ONE;
                    state_next = RD_DATA;
                end else begin
                    lat_next = lat_reg - 4'd1;
                end
            end

            RD_DATA: begin
                if (end_transaction_in) begin
                    state_next = IDLE;
                end else if (count_reg == 9'd0) begin
                    state_next = RD_END;
                    end_next   = 1'b1;
                end else begin
                    issue      = 1'b1;
                    valid_next = 1'b1;
                    ptr_next   = ptr_reg + PTR_ONE;
                    count_next = count_reg - 9'd1;
                end
            end

            RD_END: begin
                state_next = IDLE;
            end

            WR_DATA: begin
                if (end_transaction_in) begin
                    state_next = IDLE;
                end else if (accept) begin
                    if (WAIT_STATES > 0) begin
                        busy_next = 1'b1;
                        wait_next = WAIT_INIT;
                    end
                end else if (busy_reg) begin
                    if (wait_reg != 4'd0) begin
                        busy_next = 1'b1;
                        wait_next = wait_reg - 4'd1;
                    end
                end
                // Words past the burst length are accepted but dropped.
                if (accept && (count_reg != 9'd0)) begin
                    mem_we     = 1'b1;
                    ptr_next   = ptr_reg + PTR_ONE;
                    count_next = count_reg - 9'd1;
                end
            end

            ERR: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            ptr_reg   <= '0;
            count_reg <= '0;
            lat_reg   <= '0;
            wait_reg  <= '0;
            be_reg    <= '0;
            busy_reg  <= 1'b0;
            valid_reg <= 1'b0;
            end_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            count_reg <= count_next;
            lat_reg   <= lat_next;
            wait_reg  <= wait_next;
            be_reg    <= be_next;
            busy_reg  <= busy_next;
            valid_reg <= valid_next;
            end_reg   <= end_next;
            err_reg   <= err_next;
        end
    end

    // One byte-wide single-port RAM per lane so lane enables map directly onto
    // independent write enables. Contents survive reset.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [DEPTH];
            logic [7:0] lane_q;

            always_ff @(posedge clock) begin
                if (mem_we && be_reg[gi]) begin
                    lane_mem[mem_addr] <= address_data_in[8*gi +: 8];
                end
                if (issue) begin
                    lane_q <= lane_mem[mem_addr];
                end
            end

            assign rd_lanes[gi] = lane_q;
        end
    endgenerate

    assign busy_out            = busy_reg;
    assign data_valid_out      = valid_reg;
    assign end_transaction_out = end_reg;
    assign error_out           = err_reg;
    // Gated by a register only, so the bus sees 0 whenever no word is valid.
    assign address_data_out    = valid_reg ? {rd_lanes[3], rd_lanes[2], rd_lanes[1], rd_lanes[0]}
                                           : 32'd0;

endmodule

// File: tb/tb_bus_burst_mem_slave.sv
// ---------------------------------------------------------------------------
// tb_bus_burst_mem_slave
//
// Two slaves share clock and reset: dut0 (base 0, READ_LATENCY 1, no wait
// states) and dut1 (base 0x10000, READ_LATENCY 0, WAIT_STATES 2). A word-array
// memory model plus per-transaction timing arithmetic gives the expected
// outputs of every cycle; a negedge process compares all outputs of both
// slaves on every cycle after the first reset edge.
// ---------------------------------------------------------------------------
module tb_bus_burst_mem_slave;

    localparam int          N     = 10;
    localparam int          DEPTH = 1 << N;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0001_0000;

    logic        clock = 1'b0;
    logic        reset = 1'b0;

    logic        bt [2];
    logic        et [2];
    logic        rnw [2];
    logic [3:0]  be [2];
    logic [7:0]  bs [2];
    logic [31:0] adi [2];
    logic        dvi [2];
    logic        busy_o [2];
    logic        dv_o [2];
    logic        eo_o [2];
    logic        err_o [2];
    logic [31:0] ado [2];

    logic        e_busy [2];
    logic        e_dv [2];
    logic        e_end [2];
    logic        e_err [2];
    logic [31:0] e_data [2];

    logic [31:0] mem_model [2][DEPTH];
    logic [31:0] wq [$];

    int dv_cyc0 [$];
    int end_cyc0 [$];
    int err_cyc0 [$];

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;
    int cyc    = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_dut
            bus_burst_mem_slave #(
                .BASE_ADDRESS   (gi == 0 ? BASE0 : BASE1),
                .ADDR_WORDS_LOG2(N),
                .READ_LATENCY   (gi == 0 ? 1 : 0),
                .WAIT_STATES    (gi == 0 ? 0 : 2)
            ) dut (
                .clock               (clock),
                .reset               (reset),
                .begin_transaction_in(bt[gi]),
                .end_transaction_in  (et[gi]),
                .read_n_write_in     (rnw[gi]),
                .byte_enables_in     (be[gi]),
                .burst_size_in       (bs[gi]),
                .address_data_in     (adi[gi]),
                .data_valid_in       (dvi[gi]),
                .busy_out            (busy_o[gi]),
                .data_valid_out      (dv_o[gi]),
                .end_transaction_out (eo_o[gi]),
                .error_out           (err_o[gi]),
                .address_data_out    (ado[gi])
            );
        end
    endgenerate

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
        end
    endtask

    // Per-cycle comparison of every output of both slaves.
    always @(negedge clock) begin
        if (chk_en) begin
            for (int d = 0; d < 2; d++) begin
                check("busy_out", d, 32'(busy_o[d]), 32'(e_busy[d]));
                check("data_valid_out", d, 32'(dv_o[d]), 32'(e_dv[d]));
                check("end_transaction_out", d, 32'(eo_o[d]), 32'(e_end[d]));
                check("error_out", d, 32'(err_o[d]), 32'(e_err[d]));
                check("address_data_out", d, ado[d], e_data[d]);
            end
        end
    end

    // Event timestamps of dut0 for the literal timing checks.
    always @(negedge clock) begin
        if (dv_o[0])  dv_cyc0.push_back(cyc);
        if (eo_o[0])  end_cyc0.push_back(cyc);
        if (err_o[0]) err_cyc0.push_back(cyc);
    end

    function automatic int first_at(input int q[$], input int from);
        foreach (q[i]) if (q[i] >= from) return q[i] - from;
        return -1;
    endfunction

    function automatic int count_in(input int q[$], input int from, input int upto);
        int n = 0;
        foreach (q[i]) if (q[i] >= from && q[i] <= upto) n++;
        return n;
    endfunction

    function automatic int rl_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    function automatic int ws_of(input int d);
        return (d == 0) ? 0 : 2;
    endfunction

    function automatic logic [31:0] waddr(input int d, input int w);
        logic [31:0] base = (d == 0) ? BASE0 : BASE1;
        return base + (32'(w % DEPTH) << 2);
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int d);
        bt[d] = 1'b0; et[d] = 1'b0; rnw[d] = 1'b0; be[d] = 4'd0; bs[d] = 8'd0;
        adi[d] = 32'd0; dvi[d] = 1'b0;
        e_busy[d] = 1'b0; e_dv[d] = 1'b0; e_end[d] = 1'b0; e_err[d] = 1'b0; e_data[d] = 32'd0;
    endtask

    // Write burst of burst+1 words from wq (plus 'extra' surplus words). Data
    // valid is held continuously; with W wait states each word occupies W+1
    // cycles, busy being high in all but the first of them.
    task automatic do_write(input int d, input int word, input int burst, input logic [3:0] ben, input int extra);
        int w = ws_of(d);
        int n = burst + 1;
        int a;
        logic [31:0] cur;
        $display("dut%0d write word %0d burst %0d be %b extra %0d", d, word, burst, ben, extra);
        idle(d);
        bt[d] = 1'b1; rnw[d] = 1'b0; be[d] = ben; bs[d] = 8'(burst); adi[d] = waddr(d, word);
        tick();
        idle(d);
        for (int k = 0; k < n + extra; k++) begin
            for (int j = 0; j <= w; j++) begin
                dvi[d] = 1'b1; adi[d] = wq[k]; e_busy[d] = (j != 0);
                tick();
            end
            if (k < n) begin
                a = (word + k) % DEPTH;
                cur = mem_model[d][a];
                for (int b = 0; b < 4; b++) if (ben[b]) cur[8*b +: 8] = wq[k][8*b +: 8];
                mem_model[d][a] = cur;
            end
        end
        idle(d);
        et[d] = 1'b1;
        tick();
        idle(d);
    endtask

    // Read burst; abort_after = k > 0 raises end_transaction_in during the
    // k-th data word, 0 runs the burst to completion.
    task automatic do_read(input int d, input int word, input int burst, input int abort_after);
        int n = burst + 1;
        bit aborted = 1'b0;
        $display("dut%0d read word %0d burst %0d abort %0d", d, word, burst, abort_after);
        idle(d);
        bt[d] = 1'b1; rnw[d] = 1'b1; bs[d] = 8'(burst); be[d] = 4'($urandom); adi[d] = waddr(d, word);
        tick();
        idle(d);
        for (int i = 0; i < rl_of(d); i++) tick();
        for (int k = 0; k < n; k++) begin
            e_dv[d] = 1'b1;
            e_data[d] = mem_model[d][(word + k) % DEPTH];
            if (abort_after == k + 1) begin
                et[d] = 1'b1;
                tick();
                aborted = 1'b1;
                break;
            end
            tick();
        end
        idle(d);
        if (!aborted) begin
            e_end[d] = 1'b1;
            tick();
            idle(d);
        end
    endtask

    task automatic do_err(input int d, input logic [31:0] addr);
        $display("dut%0d misaligned begin at %h", d, addr);
        idle(d);
        bt[d] = 1'b1; rnw[d] = 1'($urandom); bs[d] = 8'($urandom); adi[d] = addr;
        tick();
        idle(d);
        e_err[d] = 1'b1; e_end[d] = 1'b1;
        tick();
        idle(d);
    endtask

    task automatic do_miss(input int d, input logic [31:0] addr);
        $display("dut%0d out-of-window begin at %h", d, addr);
        idle(d);
        bt[d] = 1'b1; rnw[d] = 1'($urandom); bs[d] = 8'($urandom); adi[d] = addr;
        tick();
        idle(d);
        tick();
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish in time (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int mark;
        int op, word, burst, abort_after, extra;
        logic [3:0] ben;
        logic [31:0] miss_addr;

        idle(0);
        idle(1);
        reset = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Fill both memories so every later read has a defined expectation.
        for (int d = 0; d < 2; d++) begin
            for (int blk = 0; blk < DEPTH / 256; blk++) begin
                wq.delete();
                repeat (256) wq.push_back($urandom);
                do_write(d, blk * 256, 255, 4'hF, 0);
            end
        end

        // Write 2,4..32 at BASE+0x40, then read it back with latency 1.
        wq.delete();
        for (int k = 0; k < 16; k++) wq.push_back(32'(2 * (k + 1)));
        do_write(0, 16, 15, 4'hF, 0);
        for (int k = 0; k < 16; k++) check("model_write_data", 0, mem_model[0][16 + k], 32'(2 * (k + 1)));
        mark = cyc;
        do_read(0, 16, 15, 0);
        check("first_word_offset", 0, 32'(first_at(dv_cyc0, mark)), 32'd2);
        check("end_offset", 0, 32'(first_at(end_cyc0, mark)), 32'd18);
        check("word_count", 0, 32'(count_in(dv_cyc0, mark, mark + 20)), 32'd16);

        // Byte enables.
        wq.delete(); wq.push_back(32'h1122_3344);
        do_write(0, 200, 0, 4'hF, 0);
        wq.delete(); wq.push_back(32'hAABB_CCDD);
        do_write(0, 200, 0, 4'b0011, 0);
        check("model_byte_enables", 0, mem_model[0][200], 32'h1122_CCDD);
        do_read(0, 200, 0, 0);

        // Misaligned hit and out-of-window begin.
        mark = cyc;
        do_err(0, BASE0 + 32'h42);
        check("error_offset", 0, 32'(first_at(err_cyc0, mark)), 32'd1);
        do_miss(0, 32'h0000_1000);
        do_miss(1, BASE0 + 32'h40);

        // Wrap across the top of the window.
        wq.delete(); wq.push_back(32'hDEAD_0001); wq.push_back(32'hBEEF_0002);
        do_write(0, DEPTH - 1, 1, 4'hF, 0);
        check("model_wrap_top", 0, mem_model[0][DEPTH - 1], 32'hDEAD_0001);
        check("model_wrap_zero", 0, mem_model[0][0], 32'hBEEF_0002);
        do_read(0, DEPTH - 1, 1, 0);

        // 16-word read aborted after 3 words.
        mark = cyc;
        do_read(0, 300, 15, 3);
        tick();
        check("abort_word_count", 0, 32'(count_in(dv_cyc0, mark, cyc)), 32'd3);
        check("abort_no_end", 0, 32'(first_at(end_cyc0, mark)), 32'hFFFF_FFFF);

        // Surplus words beyond the burst are dropped.
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back($urandom);
        do_write(0, 400, 1, 4'hF, 2);
        do_read(0, 400, 3, 0);

        // Reset for two cycles in the middle of a read; memory must survive.
        $display("dut0 reset during read burst");
        idle(0);
        bt[0] = 1'b1; rnw[0] = 1'b1; bs[0] = 8'd15; adi[0] = waddr(0, 100);
        tick();
        idle(0);
        tick();
        e_dv[0] = 1'b1; e_data[0] = mem_model[0][100];
        tick();
        e_data[0] = mem_model[0][101];
        tick();
        reset = 1'b0;
        idle(0);
        tick();
        tick();
        reset = 1'b1;
        tick();
        do_read(0, 100, 15, 0);

        // Back-pressure: 4 words with two wait states, then read back.
        wq.delete();
        for (int k = 0; k < 4; k++) wq.push_back($urandom);
        do_write(1, 50, 3, 4'hF, 0);
        do_read(1, 50, 3, 0);

        // Randomized traffic on both slaves.
        for (int d = 0; d < 2; d++) begin
            for (int t = 0; t < 80; t++) begin
                op = $urandom_range(0, 9);
                word = $urandom_range(0, DEPTH - 1);
                burst = $urandom_range(0, 15);
                ben = 4'($urandom);
                if (op <= 3) begin
                    extra = (ws_of(d) == 0) ? $urandom_range(0, 2) : 0;
                    wq.delete();
                    repeat (burst + 1 + extra) wq.push_back($urandom);
                    do_write(d, word, burst, ben, extra);
                end else if (op <= 7) begin
                    abort_after = ($urandom_range(0, 3) == 0) ? $urandom_range(1, burst + 1) : 0;
                    do_read(d, word, burst, abort_after);
                end else if (op == 8) begin
                    do_err(d, waddr(d, word) + 32'($urandom_range(1, 3)));
                end else begin
                    miss_addr = waddr(d, word) + (32'($urandom_range(1, (1 << 20) - 1)) << 12);
                    do_miss(d, miss_addr);
                end
                repeat ($urandom_range(0, 2)) tick();
            end
        end

        tick();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
